// File: rtl/gate_input_debouncer.sv
// Two-channel synchronise-and-debounce front end for and_gate_decoder.
// Emits clean a/b, a one-cycle change pulse and a saturating bounce counter.
module gate_input_debouncer #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_raw,
   input  logic       b_raw,
   output logic       a,
   output logic       b,
   output logic       change,
   output logic [7:0] bounce_cnt
);

   typedef enum logic {ST_STABLE = 1'b0, ST_PENDING = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             a_s1_r, a_s2_r, b_s1_r, b_s2_r;
   logic [1:0]       smp_s;
   state_t           state_r     [2];
   state_t           state_nxt_s [2];
   logic [CNT_W-1:0] cnt_r       [2];
   logic [CNT_W-1:0] cnt_nxt_s   [2];
   logic [1:0]       q_r, q_nxt_s;
   logic [1:0]       upd_s, bnc_s;
   logic [1:0]       bnc_num_s;
   logic             change_r;
   logic [7:0]       bounce_cnt_r;

   function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, base} + {7'b0000000, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   assign smp_s     = {b_s2_r, a_s2_r};
   assign bnc_num_s = {1'b0, bnc_s[0]} + {1'b0, bnc_s[1]};

   // Per-channel debounce FSM next state; channel 0 is A, channel 1 is B.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      q_nxt_s     = q_r;
      upd_s       = 2'b00;
      bnc_s       = 2'b00;
      for (int i = 0; i < 2; i++) begin
         case (state_r[i])
            ST_STABLE: begin
               if (smp_s[i] != q_r[i]) begin
                  state_nxt_s[i] = ST_PENDING;
                  cnt_nxt_s[i]   = CNT_W'(1);
               end else begin
                  cnt_nxt_s[i]   = '0;
               end
            end
            ST_PENDING: begin
               if (smp_s[i] == q_r[i]) begin
                  state_nxt_s[i] = ST_STABLE;
                  cnt_nxt_s[i]   = '0;
                  bnc_s[i]       = 1'b1;
               end else if (cnt_r[i] == CNT_LAST) begin
                  state_nxt_s[i] = ST_STABLE;
                  cnt_nxt_s[i]   = '0;
                  q_nxt_s[i]     = smp_s[i];
                  upd_s[i]       = 1'b1;
               end else begin
                  cnt_nxt_s[i]   = cnt_r[i] + CNT_W'(1);
               end
            end
            default: begin
               state_nxt_s[i] = ST_STABLE;
               cnt_nxt_s[i]   = '0;
            end
         endcase
      end
   end

   // Synchronisers, FSM state and registered outputs; reset discards any pending debounce.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_s1_r       <= 1'b0;
         a_s2_r       <= 1'b0;
         b_s1_r       <= 1'b0;
         b_s2_r       <= 1'b0;
         q_r          <= 2'b00;
         change_r     <= 1'b0;
         bounce_cnt_r <= 8'd0;
         for (int i = 0; i < 2; i++) begin
            state_r[i] <= ST_STABLE;
            cnt_r[i]   <= '0;
         end
      end else begin
         a_s1_r       <= a_raw;
         a_s2_r       <= a_s1_r;
         b_s1_r       <= b_raw;
         b_s2_r       <= b_s1_r;
         q_r          <= q_nxt_s;
         change_r     <= |upd_s;
         bounce_cnt_r <= sat_add8(bounce_cnt_r, bnc_num_s);
         for (int i = 0; i < 2; i++) begin
            state_r[i] <= state_nxt_s[i];
            cnt_r[i]   <= cnt_nxt_s[i];
         end
      end
   end

   assign a          = q_r[0];
   assign b          = q_r[1];
   assign change     = change_r;
   assign bounce_cnt = bounce_cnt_r;

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Scoreboard bench for gate_input_debouncer: each scenario queues its expected
// outputs per edge from the documented timing and checks them one edge later.
module tb_gate_input_debouncer;

   logic       clk;
   logic       rst;
   logic       a_raw;
   logic       b_raw;
   logic       a;
   logic       b;
   logic       change;
   logic [7:0] bounce_cnt;

   typedef struct {
      logic       a;
      logic       b;
      logic       chg;
      logic [7:0] bc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;

   gate_input_debouncer #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .a_raw      (a_raw),
      .b_raw      (b_raw),
      .a          (a),
      .b          (b),
      .change     (change),
      .bounce_cnt (bounce_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic do_reset();
      rst   = 1'b1;
      a_raw = 1'b0;
      b_raw = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst   = 1'b1;
      a_raw = 1'b1;
      b_raw = 1'b1;
      for (int k = 0; k < 3; k++) begin
         e.a = 1'b0; e.b = 1'b0; e.chg = 1'b0; e.bc = 8'd0;
         exp_q.push_back(e);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({a, b, change, bounce_cnt} !== {e.a, e.b, e.chg, e.bc}) begin
            fails++;
            $display("FAIL reset cyc %0d: got a=%b b=%b change=%b bounce_cnt=%0d, expected a=%b b=%b change=%b bounce_cnt=%0d",
                     k, a, b, change, bounce_cnt, e.a, e.b, e.chg, e.bc);
         end
      end
   endtask

   task automatic test_clean_rise();
      exp_t e;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         a_raw = 1'b1;
         b_raw = 1'b0;
         e.a = (k >= 5); e.b = 1'b0; e.chg = (k == 5); e.bc = 8'd0;
         exp_q.push_back(e);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({a, b, change, bounce_cnt} !== {e.a, e.b, e.chg, e.bc}) begin
            fails++;
            $display("FAIL clean_rise E%0d: got a=%b b=%b change=%b bounce_cnt=%0d, expected a=%b b=%b change=%b bounce_cnt=%0d",
                     k, a, b, change, bounce_cnt, e.a, e.b, e.chg, e.bc);
         end
      end
   endtask

   task automatic test_bounce();
      exp_t e;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         a_raw = (k < 3);
         b_raw = 1'b0;
         e.a = 1'b0; e.b = 1'b0; e.chg = 1'b0; e.bc = (k >= 5) ? 8'd1 : 8'd0;
         exp_q.push_back(e);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({a, b, change, bounce_cnt} !== {e.a, e.b, e.chg, e.bc}) begin
            fails++;
            $display("FAIL bounce E%0d: got a=%b b=%b change=%b bounce_cnt=%0d, expected a=%b b=%b change=%b bounce_cnt=%0d",
                     k, a, b, change, bounce_cnt, e.a, e.b, e.chg, e.bc);
         end
      end
   endtask

   // Shortest accepted pulse: four samples rise at E5 and fall again four edges later.
   task automatic test_min_pulse();
      exp_t e;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         a_raw = (k < 4);
         b_raw = 1'b0;
         e.a = (k >= 5 && k < 9); e.b = 1'b0; e.chg = (k == 5 || k == 9); e.bc = 8'd0;
         exp_q.push_back(e);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({a, b, change, bounce_cnt} !== {e.a, e.b, e.chg, e.bc}) begin
            fails++;
            $display("FAIL min_pulse E%0d: got a=%b b=%b change=%b bounce_cnt=%0d, expected a=%b b=%b change=%b bounce_cnt=%0d",
                     k, a, b, change, bounce_cnt, e.a, e.b, e.chg, e.bc);
         end
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         a_raw = 1'b1;
         b_raw = 1'b1;
         e.a = (k >= 5); e.b = (k >= 5); e.chg = (k == 5); e.bc = 8'd0;
         exp_q.push_back(e);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({a, b, change, bounce_cnt} !== {e.a, e.b, e.chg, e.bc}) begin
            fails++;
            $display("FAIL simultaneous E%0d: got a=%b b=%b change=%b bounce_cnt=%0d, expected a=%b b=%b change=%b bounce_cnt=%0d",
                     k, a, b, change, bounce_cnt, e.a, e.b, e.chg, e.bc);
         end
         checks++;
         if ((a & b) !== (e.a & e.b)) begin
            fails++;
            $display("FAIL and_o E%0d: got %b, expected %b", k, a & b, e.a & e.b);
         end
      end
   endtask

   // Edges 0-1 start a debounce, edge 2 is reset, edge 3 is the fresh E0.
   task automatic test_reset_mid_pending();
      exp_t e;
      do_reset();
      for (int k = 0; k < 11; k++) begin
         a_raw = 1'b1;
         b_raw = 1'b0;
         rst   = (k == 2);
         e.a = (k >= 8); e.b = 1'b0; e.chg = (k == 8); e.bc = 8'd0;
         exp_q.push_back(e);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({a, b, change, bounce_cnt} !== {e.a, e.b, e.chg, e.bc}) begin
            fails++;
            $display("FAIL reset_mid_pending edge %0d: got a=%b b=%b change=%b bounce_cnt=%0d, expected a=%b b=%b change=%b bounce_cnt=%0d",
                     k, a, b, change, bounce_cnt, e.a, e.b, e.chg, e.bc);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_saturation(input logic both, input int periods);
      exp_t e;
      logic chg_seen;
      int   total;
      chg_seen = 1'b0;
      do_reset();
      for (int p = 0; p < periods; p++) begin
         for (int k = 0; k < 6; k++) begin
            a_raw = (k < 3);
            b_raw = both & (k < 3);
            if (k == 5) begin
               total = both ? 2 * (p + 1) : p + 1;
               e.a = 1'b0; e.b = 1'b0; e.chg = 1'b0;
               e.bc = (total > 255) ? 8'd255 : 8'(total);
               exp_q.push_back(e);
            end
            @(posedge clk); #1;
            if (change === 1'b1) chg_seen = 1'b1;
            if (k == 5) begin
               e = exp_q.pop_front();
               checks++;
               if ({a, b, change, bounce_cnt} !== {e.a, e.b, e.chg, e.bc}) begin
                  fails++;
                  $display("FAIL saturation both=%b period %0d: got a=%b b=%b change=%b bounce_cnt=%0d, expected a=%b b=%b change=%b bounce_cnt=%0d",
                           both, p, a, b, change, bounce_cnt, e.a, e.b, e.chg, e.bc);
               end
            end
         end
      end
      checks++;
      if (chg_seen !== 1'b0) begin
         fails++;
         $display("FAIL saturation_change both=%b: got change pulse, expected none", both);
      end
   endtask

   initial begin
      rst   = 1'b1;
      a_raw = 1'b0;
      b_raw = 1'b0;
      test_reset();
      test_clean_rise();
      test_bounce();
      test_min_pulse();
      test_simultaneous();
      test_reset_mid_pending();
      test_saturation(1'b0, 260);
      test_saturation(1'b1, 130);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/gate_input_debouncer.md
# gate_input_debouncer

Front-end stage for `and_gate_decoder`. It takes two raw, asynchronous, possibly bouncing inputs from switches or pins. It synchronises and debounces each one and drives clean, glitch-free `a` and `b` straight into the decoder's `a`/`b` ports. It also flags every clean-input update with a one-cycle pulse and counts rejected bounces for bring-up visibility.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive synchronised samples that must differ from the clean value before the clean value flips. Legal range is ≥2.
- `CNT_W`, default 3: width of the per-channel debounce counter. Must hold `STABLE_CYCLES-1`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `a_raw`  in  1: raw asynchronous input, channel A.
- `b_raw`  in  1: raw asynchronous input, channel B.
- `a`  out  1: debounced channel A, registered; connects to `and_gate_decoder.a`.
- `b`  out  1: debounced channel B, registered; connects to `and_gate_decoder.b`.
- `change`  out  1: one-cycle pulse; asserted in the cycle after `a` and/or `b` updated.
- `bounce_cnt`  out  8: saturating count of aborted debounce attempts across both channels.

## Operation
- **Synchroniser:** each raw input passes through a 2-flop synchroniser (`x_s1`, then `x_s2`). Only `x_s2` feeds the FSM.
- **Channel FSM:** each channel has an independent FSM with a counter `cnt` and a clean value `q` (`q` drives `a` or `b`).
  - **STABLE:** if `x_s2 == q`, stay and hold `cnt = 0`. If `x_s2 != q`, go to PENDING with `cnt <= 1`.
  - **PENDING, `x_s2 == q`:** the input bounced back. Go to STABLE, set `cnt <= 0`, and register one bounce.
  - **PENDING, `x_s2 != q` and `cnt < STABLE_CYCLES-1`:** `cnt <= cnt+1`.
  - **PENDING, `x_s2 != q` and `cnt == STABLE_CYCLES-1`:** `q <= x_s2`, `cnt <= 0`, go to STABLE. This is an update event.
- **`change`:** registered OR of both channels' update events. If both channels update on the same edge, `change` produces a single one-cycle pulse.
- **`bounce_cnt`:** adds the number of bounces this edge (0, 1 or 2). It saturates at 255 and never wraps; if 254 and two bounces arrive, the result is 255.
- **Reset:**
  - `a = 0`, `b = 0`, `change = 0`, `bounce_cnt = 0`.
  - Both synchroniser stages = 0, both FSMs in STABLE with `cnt = 0`.
  - Reset has priority over all other updates.
  - A pending debounce is discarded; no bounce is counted for it.
- Outputs never change combinationally from `a_raw`/`b_raw`.

## Timing
- Let E0 be the first rising edge that samples a new raw level into `x_s1`, with the raw level held afterwards.
  - `x_s2` takes the new level at E1.
  - The FSM enters PENDING at E2.
  - `q` (and so `a`/`b`) updates at edge E(STABLE_CYCLES+1), which is E5 at the default setting.
  - `change` is high for exactly the cycle following that edge.
- Total latency from raw change to clean output is STABLE_CYCLES+2 edges, counting E0.
- A raw pulse shorter than STABLE_CYCLES synchronised samples never reaches `a`/`b`.
  - It increments `bounce_cnt` once, on the edge where `x_s2` returns to `q`.
- While `rst` is high, no events occur. The first post-reset sampling edge acts as a fresh E0.
- The `and_gate_decoder` output follows `a & b` with no added latency beyond this block.

## Test plan
- **Reset:** `a_raw = b_raw = 1` with `rst` high for 3 cycles → `a = b = 0`, `change = 0`, `bounce_cnt = 0` throughout the reset cycles.
- **Clean rise:** `a_raw` 0→1 and held, `b_raw = 0` → `a` rises at E5, `change` is high for exactly one cycle after E5, `b` stays 0, `bounce_cnt = 0`.
- **Bounce rejection:** `a_raw` high for 3 cycles then low → `a` stays 0, `change` never asserts, `bounce_cnt` becomes 1.
- **Simultaneous update:** `a_raw` and `b_raw` both 0→1 on the same cycle → `a` and `b` rise on the same edge (E5), a single one-cycle `change` pulse, downstream `and_o = 1`.
- **Reset mid-pending:** `a_raw` high for 2 cycles, `rst` pulsed for 1 cycle, `a_raw` still high → `a = 0` and `bounce_cnt = 0` after reset; `a` rises at E5 counted from the first post-reset edge.
- **Saturation:** 260 three-cycle bounces on `a_raw` → `bounce_cnt` reads 255 and stays there; `a` remains 0.
